// File: rtl/pipelined_csel_addsub.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment is resolved per stage,
// with a global valid/ready stall and registered carry, overflow and zero flags.
module pipelined_csel_addsub #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             co,
   output logic             ovf,
   output logic             zero
);

   localparam int NSEG = WIDTH / SEG;

   typedef logic [WIDTH-1:0] word_t;
   typedef logic [SEG-1:0]   seg_t;

   localparam logic [SEG:0] ONE = 1;

   logic stall;

   // The pending segment of each operand always sits in the low bits.
   // Resolved sum bits enter at the top and shift down, so they end up in place.
   logic [NSEG-1:0]             vld_q;
   logic [NSEG-1:0][WIDTH-1:0]  opa_q;
   logic [NSEG-1:0][WIDTH-1:0]  opb_q;
   logic [NSEG-1:0][WIDTH-1:0]  res_q;
   logic [NSEG-1:0]             cy_q;
   logic [NSEG-1:0]             asgn_q;
   logic [NSEG-1:0]             bsgn_q;

   logic [NSEG-1:0][WIDTH-1:0]  res_nx;
   logic [NSEG-1:0]             cy_nx;

   logic [SEG:0] sum0;
   logic [SEG:0] sum1;
   logic [SEG:0] sel;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   always_comb begin
      sum0   = '0;
      sum1   = '0;
      sel    = '0;
      res_nx = '0;
      cy_nx  = '0;
      for (int k = 0; k < NSEG; k++) begin
         sum0      = {1'b0, seg_t'(opa_q[k])} + {1'b0, seg_t'(opb_q[k])};
         sum1      = sum0 + ONE;
         sel       = cy_q[k] ? sum1 : sum0;
         res_nx[k] = (res_q[k] >> SEG) | (word_t'(sel[SEG-1:0]) << (WIDTH - SEG));
         cy_nx[k]  = sel[SEG];
      end
   end

   // Stage 0 conditions the operands; later stages advance the skewed operands
   // and the partially resolved result; the final stage registers the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q     <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         res_q     <= '0;
         cy_q      <= '0;
         asgn_q    <= '0;
         bsgn_q    <= '0;
         out_valid <= 1'b0;
         out       <= '0;
         co        <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else if (!stall) begin
         vld_q[0]  <= in_valid;
         opa_q[0]  <= inA;
         opb_q[0]  <= sub ? ~inB : inB;
         res_q[0]  <= '0;
         cy_q[0]   <= sub ^ ci;
         asgn_q[0] <= inA[WIDTH-1];
         bsgn_q[0] <= sub ^ inB[WIDTH-1];
         for (int k = 1; k < NSEG; k++) begin
            vld_q[k]  <= vld_q[k-1];
            opa_q[k]  <= opa_q[k-1] >> SEG;
            opb_q[k]  <= opb_q[k-1] >> SEG;
            res_q[k]  <= res_nx[k-1];
            cy_q[k]   <= cy_nx[k-1];
            asgn_q[k] <= asgn_q[k-1];
            bsgn_q[k] <= bsgn_q[k-1];
         end
         out_valid <= vld_q[NSEG-1];
         out       <= res_nx[NSEG-1];
         co        <= cy_nx[NSEG-1];
         ovf       <= (asgn_q[NSEG-1] == bsgn_q[NSEG-1]) &&
                      (res_nx[NSEG-1][WIDTH-1] != asgn_q[NSEG-1]);
         zero      <= ~|res_nx[NSEG-1];
      end
   end

endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// Directed and randomised checks of pipelined_csel_addsub at three width/segment settings.
module tb_pipelined_csel_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf, zero;
   logic [31:0] in_a, in_b, out;

   logic        s16_in_valid, s16_in_ready, s16_ci, s16_sub, s16_out_valid, s16_out_ready;
   logic        s16_co, s16_ovf, s16_zero;
   logic [15:0] s16_a, s16_b, s16_out;

   logic        s8_in_valid, s8_in_ready, s8_ci, s8_sub, s8_out_valid, s8_out_ready;
   logic        s8_co, s8_ovf, s8_zero;
   logic [7:0]  s8_a, s8_b, s8_out;

   int n_vec  = 0;
   int n_fail = 0;

   pipelined_csel_addsub #(.WIDTH(32), .SEG(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .inA(in_a), .inB(in_b), .ci(ci), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .co(co), .ovf(ovf), .zero(zero)
   );

   pipelined_csel_addsub #(.WIDTH(16), .SEG(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(s16_in_valid), .in_ready(s16_in_ready),
      .inA(s16_a), .inB(s16_b), .ci(s16_ci), .sub(s16_sub), .out_valid(s16_out_valid),
      .out_ready(s16_out_ready), .out(s16_out), .co(s16_co), .ovf(s16_ovf), .zero(s16_zero)
   );

   pipelined_csel_addsub #(.WIDTH(8), .SEG(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
      .inA(s8_a), .inB(s8_b), .ci(s8_ci), .sub(s8_sub), .out_valid(s8_out_valid),
      .out_ready(s8_out_ready), .out(s8_out), .co(s8_co), .ovf(s8_ovf), .zero(s8_zero)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        c;
      logic        s;
      logic [31:0] exp_out;
      logic        exp_co;
      logic        exp_ovf;
      logic        exp_zero;
   } vec_t;

   vec_t vecs [11];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      ci       = c;
      sub      = s;
      in_valid = 1'b1;
   endtask

   // One isolated operation: accept, then expect the result exactly five cycles later.
   task automatic runSingle(input string name, input vec_t v);
      int lat;
      applyStimulus(v.a, v.b, v.c, v.s);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({name, "_latency"}, lat, 5);
      checkOutput({name, "_out"}, out, v.exp_out);
      checkOutput({name, "_co"}, co, v.exp_co);
      checkOutput({name, "_ovf"}, ovf, v.exp_ovf);
      checkOutput({name, "_zero"}, zero, v.exp_zero);
   endtask

   function automatic logic [34:0] refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic c, input logic s);
      logic [63:0] mask, av, bv, bop, full, res;
      mask = (64'd1 << w) - 64'd1;
      av   = {32'b0, a} & mask;
      bv   = {32'b0, b} & mask;
      bop  = s ? (~bv & mask) : bv;
      full = av + bop + {63'b0, s ? ~c : c};
      res  = full & mask;
      return {res[31:0], full[w], (av[w-1] == bop[w-1]) && (res[w-1] != av[w-1]), res == 64'd0};
   endfunction

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] b2b_a   [4];
      logic [31:0] b2b_b   [4];
      logic [31:0] b2b_out [4];
      logic        b2b_ovf [4];
      logic [31:0] bp_out  [4];
      logic [34:0] q16 [$];
      logic [34:0] q8  [$];
      logic [34:0] e;
      vec_t        rv;
      int          delivered, pulses;
      int          acc16, got16, acc8, got8;

      vecs = '{
         '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1},
         '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0},
         '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0},
         '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0},
         '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0},
         '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1},
         '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0},
         '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1},
         '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0},
         '{32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1},
         '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}
      };
      b2b_a   = '{32'h1, 32'h2, 32'h00FF00FF, 32'h7FFFFFFF};
      b2b_b   = '{32'h1, 32'h2, 32'h00010001, 32'h1};
      b2b_out = '{32'h2, 32'h4, 32'h01000100, 32'h80000000};
      b2b_ovf = '{1'b0, 1'b0, 1'b0, 1'b1};
      bp_out  = '{32'h11, 32'h22, 32'h33, 32'h44};

      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b0;
      s16_in_valid = 1'b0; s16_a = '0; s16_b = '0; s16_ci = 1'b0; s16_sub = 1'b0; s16_out_ready = 1'b1;
      s8_in_valid  = 1'b0; s8_a  = '0; s8_b  = '0; s8_ci  = 1'b0; s8_sub  = 1'b0; s8_out_ready  = 1'b1;

      repeat (3) @(negedge clk);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_out", out, 0);
      checkOutput("reset_co", co, 0);
      checkOutput("reset_ovf", ovf, 0);
      checkOutput("reset_zero", zero, 0);
      checkOutput("reset_in_ready", in_ready, 1);
      rst_n = 1'b1;
      out_ready = 1'b1;

      for (int i = 0; i < 11; i++) runSingle($sformatf("vec%0d", i), vecs[i]);

      // Four accepts back to back, results expected in consecutive cycles 5..8.
      for (int i = 0; i < 4; i++) applyStimulus(b2b_a[i], b2b_b[i], 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("b2b_cycle4_valid", out_valid, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput($sformatf("b2b%0d_valid", i), out_valid, 1);
         checkOutput($sformatf("b2b%0d_out", i), out, b2b_out[i]);
         checkOutput($sformatf("b2b%0d_ovf", i), ovf, b2b_ovf[i]);
      end
      @(negedge clk);
      checkOutput("b2b_cycle9_valid", out_valid, 0);

      // Backpressure: hold the first result for three cycles with a fourth op waiting upstream.
      out_ready = 1'b0;
      applyStimulus(32'h10, 32'h1, 1'b0, 1'b0);
      applyStimulus(32'h20, 32'h2, 1'b0, 1'b0);
      applyStimulus(32'h30, 32'h3, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("bp_cycle4_valid", out_valid, 0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         in_a = 32'h40; in_b = 32'h4; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
         #1;
         checkOutput($sformatf("bp_hold%0d_valid", j), out_valid, 1);
         checkOutput($sformatf("bp_hold%0d_out", j), out, 32'h11);
         checkOutput($sformatf("bp_hold%0d_co", j), co, 0);
         checkOutput($sformatf("bp_hold%0d_in_ready", j), in_ready, 0);
      end
      delivered = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (j == 0) out_ready = 1'b1;
         if (j == 1) in_valid = 1'b0;
         #1;
         if (j == 0) checkOutput("bp_release_in_ready", in_ready, 1);
         if (out_valid && out_ready) begin
            if (delivered < 4) checkOutput($sformatf("bp_result%0d", delivered), out, bp_out[delivered]);
            delivered++;
         end
      end
      checkOutput("bp_delivered_count", delivered, 4);

      // Reset with five operations in flight, the oldest stalled at the output.
      applyStimulus(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
      for (int i = 1; i < 5; i++) applyStimulus(i, i, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      checkOutput("prerst_valid", out_valid, 1);
      checkOutput("prerst_zero", zero, 1);
      checkOutput("prerst_in_ready", in_ready, 0);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", out_valid, 0);
      checkOutput("midrst_out", out, 0);
      checkOutput("midrst_co", co, 0);
      checkOutput("midrst_ovf", ovf, 0);
      checkOutput("midrst_zero", zero, 0);
      checkOutput("midrst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      pulses = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      checkOutput("postrst_no_valid", pulses, 0);
      rv = '{32'h00001234, 32'h00004321, 1'b0, 1'b0, 32'h00005555, 1'b0, 1'b0, 1'b0};
      runSingle("postrst", rv);

      // Random traffic with random backpressure on the 16/4 and 8/8 configurations.
      acc16 = 0; got16 = 0; acc8 = 0; got8 = 0;
      for (int cyc = 0; cyc < 20000 && (got16 < 1000 || got8 < 1000); cyc++) begin
         @(negedge clk);
         s16_in_valid  = (acc16 < 1000) && ($urandom_range(3) != 0);
         s16_a         = 16'($urandom);
         s16_b         = 16'($urandom);
         s16_ci        = 1'($urandom);
         s16_sub       = 1'($urandom);
         s16_out_ready = ($urandom_range(3) != 0);
         s8_in_valid   = (acc8 < 1000) && ($urandom_range(3) != 0);
         s8_a          = 8'($urandom);
         s8_b          = 8'($urandom);
         s8_ci         = 1'($urandom);
         s8_sub        = 1'($urandom);
         s8_out_ready  = ($urandom_range(3) != 0);
         #1;
         if (s16_out_valid && s16_out_ready) begin
            e = (q16.size() > 0) ? q16.pop_front() : 'x;
            checkOutput($sformatf("rnd16_%0d", got16), {16'b0, s16_out, s16_co, s16_ovf, s16_zero}, e);
            got16++;
         end
         if (s16_in_valid && s16_in_ready) begin
            q16.push_back(refModel(16, {16'b0, s16_a}, {16'b0, s16_b}, s16_ci, s16_sub));
            acc16++;
         end
         if (s8_out_valid && s8_out_ready) begin
            e = (q8.size() > 0) ? q8.pop_front() : 'x;
            checkOutput($sformatf("rnd8_%0d", got8), {24'b0, s8_out, s8_co, s8_ovf, s8_zero}, e);
            got8++;
         end
         if (s8_in_valid && s8_in_ready) begin
            q8.push_back(refModel(8, {24'b0, s8_a}, {24'b0, s8_b}, s8_ci, s8_sub));
            acc8++;
         end
      end
      s16_in_valid = 1'b0;
      s8_in_valid  = 1'b0;
      checkOutput("rnd16_count", got16, 1000);
      checkOutput("rnd8_count", got8, 1000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
